// File: rtl/issue_scoreboard_if.sv
// issue_scoreboard_if: ID-stage issue, writeback and redirect signals between decoder, pipeline and issue_scoreboard
// Ports (slave = scoreboard view):
//     id_valid_i/id_opcode_i/id_rd_i/id_rs1_i/id_rs2_i  decoded instruction in ID
//     id_ready_o/issue_valid_o                          instruction accepted, ID/EX valid
//     wb_valid_i/wb_rd_i                                writeback completion
//     redirect_i                                        taken branch/jump resolved in EX
//     illegal_o/pending_o/stall_cnt_o                   status
interface issue_scoreboard_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid_i;
    logic [6:0]             id_opcode_i;
    logic [4:0]             id_rd_i;
    logic [4:0]             id_rs1_i;
    logic [4:0]             id_rs2_i;
    logic                   id_ready_o;
    logic                   issue_valid_o;
    logic                   wb_valid_i;
    logic [4:0]             wb_rd_i;
    logic                   redirect_i;
    logic                   illegal_o;
    logic [31:0]            pending_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;
    modport slave (
        input  id_valid_i, id_opcode_i, id_rd_i, id_rs1_i, id_rs2_i, wb_valid_i, wb_rd_i, redirect_i,
        output id_ready_o, issue_valid_o, illegal_o, pending_o, stall_cnt_o
    );
    modport master (
        output id_valid_i, id_opcode_i, id_rd_i, id_rs1_i, id_rs2_i, wb_valid_i, wb_rd_i, redirect_i,
        input  id_ready_o, issue_valid_o, illegal_o, pending_o, stall_cnt_o
    );
endinterface

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: RV32I decode-stage issue control with RAW/WAW scoreboard, redirect flush window and illegal-opcode halt
// Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     bus    issue_scoreboard_if.slave (instruction in, issue out, writeback, redirect, status)
module issue_scoreboard #(
    parameter int FLUSH_CYCLES = 2,
    parameter bit WB_BYPASS    = 1'b1,
    parameter int STALL_CNT_W  = 16
) (
    input logic               clk,
    input logic               reset,
    issue_scoreboard_if.slave bus
);
    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    state_t                 state_q, state_d;
    logic [2:0]             flush_q, flush_d;
    logic [31:0]            pending_q, pending_d;
    logic                   illegal_q, illegal_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   legal, use_rs1, use_rs2, writes_rd;
    logic [31:0]            wb_oh, rd_oh, eff;
    logic                   hazard, ready;
    always_comb begin
        {legal, use_rs1, use_rs2, writes_rd} = 4'b0000;
        case (bus.id_opcode_i)
            7'b0110011:                         {legal, use_rs1, use_rs2, writes_rd} = 4'b1111;
            7'b0010011, 7'b0000011, 7'b1100111: {legal, use_rs1, use_rs2, writes_rd} = 4'b1101;
            7'b0100011, 7'b1100011:             {legal, use_rs1, use_rs2, writes_rd} = 4'b1110;
            7'b1101111, 7'b0110111, 7'b0010111: {legal, use_rs1, use_rs2, writes_rd} = 4'b1001;
            default:                            {legal, use_rs1, use_rs2, writes_rd} = 4'b0000;
        endcase
    end
    assign wb_oh  = 32'd1 << bus.wb_rd_i;
    // x0 never becomes pending
    assign rd_oh  = (32'd1 << bus.id_rd_i) & ~32'd1;
    assign eff    = pending_q & ~((WB_BYPASS && bus.wb_valid_i) ? wb_oh : 32'd0);
    assign hazard = (use_rs1 & eff[bus.id_rs1_i]) | (use_rs2 & eff[bus.id_rs2_i]) | (writes_rd & eff[bus.id_rd_i]);
    assign ready  = !reset && state_q == RUN && bus.id_valid_i && legal && !hazard && !bus.redirect_i;
    assign bus.id_ready_o    = ready;
    assign bus.issue_valid_o = ready;
    assign bus.illegal_o     = illegal_q;
    assign bus.pending_o     = pending_q;
    assign bus.stall_cnt_o   = stall_q;
    // clear before set so a same-cycle reissue of the retiring register stays pending
    assign pending_d = (pending_q & ~(bus.wb_valid_i ? wb_oh : 32'd0)) | ((ready && writes_rd) ? rd_oh : 32'd0);
    assign stall_d   = (state_q == RUN && bus.id_valid_i && legal && !ready && !(&stall_q)) ? stall_q + STALL_CNT_W'(1) : stall_q;
    always_comb begin
        state_d   = state_q;
        flush_d   = flush_q;
        illegal_d = illegal_q;
        case (state_q)
            RUN: begin
                if (bus.redirect_i) begin
                    state_d = FLUSH;
                    flush_d = FLUSH_LOAD;
                end else if (bus.id_valid_i && !legal) begin
                    state_d   = HALT;
                    illegal_d = 1'b1;
                end
            end
            FLUSH: begin
                if (bus.redirect_i) flush_d = FLUSH_LOAD;
                else if (flush_q == 3'd0) state_d = RUN;
                else flush_d = flush_q - 3'd1;
            end
            default: state_d = state_q;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            flush_q   <= 3'd0;
            pending_q <= 32'd0;
            illegal_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            pending_q <= pending_d;
            illegal_q <= illegal_d;
            stall_q   <= stall_d;
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// tb_issue_scoreboard: table-driven scoreboard bench for issue_scoreboard plus a second instance for bypass-off, short flush and saturation
module tb_issue_scoreboard;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_BAD = 7'b1111111;
    typedef struct {
        logic        rst;
        logic        val;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        redir;
        logic        rdy;
        logic [31:0] pend;
        logic        ill;
        logic [15:0] stall;
    } vec_t;
    typedef struct {
        int          idx;
        logic        rdy;
        logic [31:0] pend;
        logic        ill;
        logic [15:0] stall;
    } exp_t;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    vec_t vt[$];
    exp_t sb[$];
    always #5 clk = ~clk;
    issue_scoreboard_if #(.STALL_CNT_W(16)) b1 ();
    issue_scoreboard_if #(.STALL_CNT_W(3))  b2 ();
    issue_scoreboard #(.FLUSH_CYCLES(2), .WB_BYPASS(1'b1), .STALL_CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(b1.slave));
    issue_scoreboard #(.FLUSH_CYCLES(1), .WB_BYPASS(1'b0), .STALL_CNT_W(3))  dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic add(input vec_t r);
        vt.push_back(r);
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk($sformatf("row%0d id_ready", e.idx), 32'(b1.id_ready_o), 32'(e.rdy));
            chk($sformatf("row%0d issue_valid", e.idx), 32'(b1.issue_valid_o), 32'(e.rdy));
            chk($sformatf("row%0d pending", e.idx), b1.pending_o, e.pend);
            chk($sformatf("row%0d illegal", e.idx), 32'(b1.illegal_o), 32'(e.ill));
            chk($sformatf("row%0d stall_cnt", e.idx), 32'(b1.stall_cnt_o), 32'(e.stall));
        end
    end
    task automatic step2(input logic v, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic wbv, input logic [4:0] wbrd, input logic redir, input logic rdy, input string nm);
        @(posedge clk);
        #1;
        b2.id_valid_i = v; b2.id_opcode_i = op; b2.id_rd_i = rd; b2.id_rs1_i = rs1; b2.id_rs2_i = 5'd0;
        b2.wb_valid_i = wbv; b2.wb_rd_i = wbrd; b2.redirect_i = redir;
        @(negedge clk);
        chk(nm, 32'(b2.id_ready_o), 32'(rdy));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        reset = 1'b1;
        b1.id_valid_i = 0; b1.id_opcode_i = 0; b1.id_rd_i = 0; b1.id_rs1_i = 0; b1.id_rs2_i = 0;
        b1.wb_valid_i = 0; b1.wb_rd_i = 0; b1.redirect_i = 0;
        b2.id_valid_i = 0; b2.id_opcode_i = 0; b2.id_rd_i = 0; b2.id_rs1_i = 0; b2.id_rs2_i = 0;
        b2.wb_valid_i = 0; b2.wb_rd_i = 0; b2.redirect_i = 0;
        // rst val op rd rs1 rs2 wbv wbrd redir | rdy pend(state this cycle) ill stall
        add('{0, 0, OP_R,   0,  0, 0, 0, 0,  0, 0, 32'h0,   0, 16'd0});
        add('{0, 1, OP_R,   5,  1, 2, 0, 0,  0, 1, 32'h0,   0, 16'd0});
        add('{0, 1, OP_ST,  5,  5, 0, 0, 0,  0, 0, 32'h20,  0, 16'd0});
        add('{0, 1, OP_ST,  5,  5, 0, 0, 0,  0, 0, 32'h20,  0, 16'd1});
        add('{0, 1, OP_ST,  5,  5, 0, 1, 5,  0, 1, 32'h20,  0, 16'd2});
        add('{0, 1, OP_LUI, 0,  0, 0, 0, 0,  0, 1, 32'h0,   0, 16'd2});
        add('{0, 1, OP_R,   3,  0, 0, 0, 0,  0, 1, 32'h0,   0, 16'd2});
        add('{0, 1, OP_I,   7,  0, 0, 0, 0,  0, 1, 32'h8,   0, 16'd2});
        add('{0, 1, OP_I,   7,  0, 0, 1, 7,  0, 1, 32'h88,  0, 16'd2});
        add('{0, 1, OP_LD,  3,  0, 0, 0, 0,  0, 0, 32'h88,  0, 16'd2});
        add('{0, 1, OP_I,   9,  0, 3, 0, 0,  0, 1, 32'h88,  0, 16'd3});
        add('{0, 1, OP_JAL, 10, 7, 3, 0, 0,  0, 1, 32'h288, 0, 16'd3});
        add('{0, 0, OP_R,   0,  0, 0, 1, 3,  0, 0, 32'h688, 0, 16'd3});
        add('{0, 0, OP_R,   0,  0, 0, 1, 20, 0, 0, 32'h680, 0, 16'd3});
        add('{0, 1, OP_BR,  0,  9, 0, 0, 0,  0, 0, 32'h680, 0, 16'd3});
        add('{0, 0, OP_R,   0,  0, 0, 1, 9,  0, 0, 32'h680, 0, 16'd4});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  1, 0, 32'h480, 0, 16'd4});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  0, 0, 32'h480, 0, 16'd5});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  0, 0, 32'h480, 0, 16'd5});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  0, 1, 32'h480, 0, 16'd5});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  1, 0, 32'h480, 0, 16'd5});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  1, 0, 32'h480, 0, 16'd6});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  0, 0, 32'h480, 0, 16'd6});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  0, 0, 32'h480, 0, 16'd6});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  0, 1, 32'h480, 0, 16'd6});
        add('{0, 1, OP_BAD, 0,  0, 0, 0, 0,  0, 0, 32'h480, 0, 16'd6});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  0, 0, 32'h480, 1, 16'd6});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  1, 0, 32'h480, 1, 16'd6});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  0, 0, 32'h480, 1, 16'd6});
        add('{1, 1, OP_AUI, 0,  0, 0, 0, 0,  0, 0, 32'h480, 1, 16'd6});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  0, 1, 32'h0,   0, 16'd0});
        add('{0, 1, OP_BAD, 0,  0, 0, 0, 0,  1, 0, 32'h0,   0, 16'd0});
        add('{0, 1, OP_BAD, 0,  0, 0, 0, 0,  0, 0, 32'h0,   0, 16'd0});
        add('{0, 0, OP_AUI, 0,  0, 0, 0, 0,  0, 0, 32'h0,   0, 16'd0});
        add('{0, 1, OP_AUI, 0,  0, 0, 0, 0,  0, 1, 32'h0,   0, 16'd0});
        repeat (2) @(posedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1;
            reset = vt[i].rst;
            b1.id_valid_i = vt[i].val; b1.id_opcode_i = vt[i].op; b1.id_rd_i = vt[i].rd;
            b1.id_rs1_i = vt[i].rs1; b1.id_rs2_i = vt[i].rs2;
            b1.wb_valid_i = vt[i].wbv; b1.wb_rd_i = vt[i].wbrd; b1.redirect_i = vt[i].redir;
            sb.push_back('{i, vt[i].rdy, vt[i].pend, vt[i].ill, vt[i].stall});
        end
        @(posedge clk);
        #1;
        b1.id_valid_i = 0; b1.wb_valid_i = 0; b1.redirect_i = 0;
        step2(1, OP_R, 4, 0, 0, 0, 0, 1, "d2 issue rd4");
        chk("d2 pending empty", b2.pending_o, 32'h0);
        step2(1, OP_I, 6, 4, 1, 4, 0, 0, "d2 wb no bypass");
        chk("d2 pending rd4", b2.pending_o, 32'h10);
        step2(1, OP_I, 6, 4, 0, 0, 0, 1, "d2 after clear");
        chk("d2 pending cleared", b2.pending_o, 32'h0);
        chk("d2 stall 1", 32'(b2.stall_cnt_o), 32'd1);
        for (int k = 0; k < 9; k++) begin
            step2(1, OP_ST, 0, 6, 0, 0, 0, 0, $sformatf("d2 stall k%0d", k));
            chk($sformatf("d2 stall_cnt k%0d", k), 32'(b2.stall_cnt_o), (k + 1 > 7) ? 32'd7 : 32'(k + 1));
        end
        step2(1, OP_ST, 0, 0, 1, 6, 1, 0, "d2 redirect");
        step2(1, OP_ST, 0, 0, 0, 0, 0, 0, "d2 flush");
        step2(1, OP_ST, 0, 0, 0, 0, 0, 1, "d2 resume");
        chk("d2 stall saturated", 32'(b2.stall_cnt_o), 32'd7);
        chk("d2 illegal clear", 32'(b2.illegal_o), 32'd0);
        if (sb.size() != 0) chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Decode-stage issue controller for the RV32I pipeline.
- Takes the decoded opcode/rd/rs1/rs2 fields of the instruction in ID and tracks outstanding register writes in a scoreboard.
- Stalls ID on RAW/WAW hazards, squashes issue for a fixed window after a branch redirect, and halts on an illegal opcode.
- Sits between the instruction field decoder and the ID/EX pipeline register; writeback reports completions back to it.

Parameters:
- FLUSH_CYCLES, 2, cycles issue is blocked after a redirect (1..7)
- WB_BYPASS, 1, 1: a writeback clear in cycle N is visible to the hazard check in cycle N; 0: visible from N+1
- STALL_CNT_W, 16, width of saturating stall counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_opcode  in  7  instruction[6:0]
- id_rd  in  5  instruction[11:7]
- id_rs1  in  5  instruction[19:15]
- id_rs2  in  5  instruction[24:20]
- id_ready  out  1  instruction accepted this cycle (ID advances)
- issue_valid  out  1  equals id_ready; drives ID/EX valid
- wb_valid  in  1  a writeback completes this cycle
- wb_rd  in  5  destination of completing writeback
- redirect  in  1  EX resolved a taken branch/jump
- illegal  out  1  sticky: illegal opcode seen
- pending  out  32  scoreboard bits, bit0 always 0
- stall_cnt  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Opcode classes (uses rs1 / uses rs2 / writes rd):
  - R 0110011: y/y/y
  - I-ALU 0010011: y/n/y
  - LOAD 0000011: y/n/y
  - STORE 0100011: y/y/n
  - BRANCH 1100011: y/y/n
  - JALR 1100111: y/n/y
  - JAL 1101111: n/n/y
  - LUI 0110111: n/n/y
  - AUIPC 0010111: n/n/y
  - any other opcode is illegal.
- Register x0 is never pending and never causes a hazard; writes to rd=0 do not set a bit.
- Effective pending mask eff = pending & ~(WB_BYPASS && wb_valid ? onehot(wb_rd) : 0).
- hazard = (uses_rs1 & eff[rs1]) | (uses_rs2 & eff[rs2]) | (writes_rd & eff[rd]) (RAW + WAW).
- FSM states:
  - RUN → FLUSH on redirect.
  - RUN → HALT on id_valid with illegal opcode and no redirect.
  - FLUSH counts down from FLUSH_CYCLES-1; at 0 returns to RUN. A redirect in FLUSH reloads the counter.
  - HALT is left only by reset; redirect is ignored in HALT.
- id_ready = issue_valid = state==RUN & id_valid & legal & !hazard & !redirect. This is combinational, the same cycle as the inputs.
- Pending update each edge: clear onehot(wb_rd) if wb_valid, then set onehot(rd) if issued and writes_rd and rd!=0. Set wins when both target the same register.
- Redirect does not alter pending. Downstream guarantees squashed in-flight instructions still deliver wb_valid/wb_rd (with register-file write suppressed), so bits always clear.
- wb_valid for a register not pending: no effect, no error.
- stall_cnt increments when state==RUN & id_valid & !id_ready (legal instruction), and saturates at all-ones.
- illegal sets when the RUN→HALT transition is taken; it stays set until reset.
- Reset (synchronous, any state, mid-stall or mid-flush): pending=0, state=RUN, flush counter=0, illegal=0, stall_cnt=0. id_ready/issue_valid are forced 0 in the reset cycle.

Test Plan:
- Reset, then issue R-type rd=5 (opcode 0110011) → id_ready=1, next cycle pending=32'h0000_0020.
- With pending[5]=1, present STORE rs1=5 → id_ready=0 and stall_cnt increments by 1 each cycle. Assert wb_valid,wb_rd=5 with WB_BYPASS=1 → id_ready=1 in that same cycle; pending[5]=0 after the edge.
- Issue LUI rd=0 → id_ready=1 and pending stays 0. Then ADD rs1=0 rs2=0 rd=3 with pending=0 → issues, pending=32'h8.
- Same cycle: wb_valid wb_rd=7 and issue I-ALU rd=7 (pending[7]=1, bypass on) → issues; pending[7]=1 after the edge.
- Assert redirect with FLUSH_CYCLES=2 and id_valid held high → id_ready=0 in the redirect cycle plus 2 cycles, then 1. A second redirect one cycle into FLUSH → 2 further blocked cycles.
- Present opcode 1111111 → id_ready=0, illegal=1 next cycle, and all later instructions blocked. Assert reset for 1 cycle → illegal=0, pending=0, issue resumes.
